// File: rtl/dff_pipe.sv
// dff_pipe: elastic delay line of DEPTH register stages, each WIDTH bits wide,
// with per-stage valid bits, valid/ready backpressure and bubble collapsing.
// Optional feature macro: DFF_PIPE_FLUSH_EN (adds a synchronous flush input).
module dff_pipe #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic                         flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] rdy;
    logic             flush_c;
    logic             in_xfer;
    logic             out_xfer;

`ifdef DFF_PIPE_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Ready chain: a stage can load if it, or any stage downstream of it, is
    // empty, or if the output stage is draining this cycle.
    always_comb begin
        logic tail_full;
        rdy       = '0;
        tail_full = 1'b1;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            tail_full = tail_full & v_q[i];
            rdy[i]    = ~tail_full | out_ready;
        end
    end

    assign in_ready  = rdy[0] & ~flush_c;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

    // Next-state: advance every stage whose ready is set; flush clears valids.
    always_comb begin
        v_d      = v_q;
        d_d      = d_q;
        count_d  = count_q;
        in_xfer  = in_valid & in_ready;
        out_xfer = v_q[DEPTH-1] & out_ready;
        if (flush_c) begin
            v_d     = '0;
            count_d = '0;
        end else begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                if (in_valid) begin
                    d_d[0] = in_data;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
                    end
                end
            end
            count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    // State registers with asynchronous reset discarding all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= RESET_VALUE;
            end
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

endmodule
